host_bus_master: RTL and testbench
==================================

HOST_BUS_MASTER -- requirements
Module: host_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles bus_valid is held waiting for bus_ready; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have ports rx_syn (input, 1, received byte available), rx_data (input, 8, received byte) and rx_ack (output, 1, byte consumed).
REQ-005 SHALL have ports tx_syn (output, 1, byte to send), tx_data (output, 8, byte to send) and tx_ack (input, 1, byte taken).
REQ-006 SHALL have bus outputs: bus_valid (1, request), bus_addr (32, word address), bus_wdata (32, write data) and bus_wstrb (4, byte enables; 0 means read).
REQ-007 SHALL have bus inputs: bus_ready (1, request complete) and bus_rdata (32, read data).

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, WDATA, BUS, RESP and ERR.
REQ-009 Byte consumption SHALL occur only on a cycle where rx_syn=1 and rx_ack=1; rx_ack SHALL be registered, pulse one cycle, and assert only in IDLE, ADDR or WDATA.
REQ-010 IDLE: 0x57 ('W') SHALL select write and 0x52 ('R') SHALL select read, each going to ADDR; any other byte SHALL go to ERR.
REQ-011 ADDR SHALL collect 4 bytes MSB first into bus_addr with bus_addr[1:0] forced to 0, then go to WDATA for a write or BUS for a read.
REQ-012 WDATA SHALL collect 4 bytes MSB first into bus_wdata, then go to BUS.
REQ-013 A 3-bit byte counter SHALL count bytes per field and clear on every field completion.
REQ-014 BUS: bus_valid SHALL be 1 with bus_addr, bus_wdata and bus_wstrb stable (wstrb 4'hf for a write, 4'h0 for a read) until the cycle bus_ready is sampled 1; bus_valid SHALL be 0 on the following cycle.
REQ-015 On bus_ready, bus_rdata SHALL be captured for a read and the FSM SHALL go to RESP.
REQ-016 A timeout counter SHALL start at 0 on BUS entry; if it reaches TIMEOUT_CYCLES without bus_ready, bus_valid SHALL drop the next cycle and the FSM SHALL go to ERR.
REQ-017 If bus_ready and timeout coincide, bus_ready SHALL win.
REQ-018 RESP, write: SHALL send the single byte 0xA5; RESP, read: SHALL send the 4 captured bytes MSB first; then go to IDLE.
REQ-019 ERR SHALL send the single byte 0xEE, then go to IDLE; rx bytes arriving in ERR, BUS or RESP SHALL stay unacknowledged.
REQ-020 tx_syn SHALL be held with tx_data stable until tx_ack=1; tx_syn SHALL drop the cycle after, and the next byte SHALL be presented no earlier than one cycle later.
REQ-021 Throughput SHALL be at most one rx byte per 2 cycles; BUS SHALL be entered the cycle after the last command byte is consumed.

Reset
REQ-022 On reset_n=0 at a clock edge, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-023 On reset, rx_ack, tx_syn and bus_valid SHALL be 0, and tx_data, bus_addr, bus_wdata, bus_wstrb and the captured rdata SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no response byte; bus_valid SHALL be 0 the cycle after reset is sampled.

Structure
REQ-025 Command codes (0x57, 0x52), response codes (0xA5, 0xEE) and FSM state encodings SHALL be localparams in a shared host_bus_pkg include used by firmware-side tests.
REQ-026 The block SHALL be a single module, except that a timeout counter sub-module bus_timeout SHALL be used for the counter.

Verification
REQ-027 Write: rx 57 40 00 00 08 DE AD BE EF -> one request with bus_valid, bus_addr=0x40000008, bus_wdata=0xDEADBEEF, bus_wstrb=f; bus_ready after 3 cycles -> tx A5.
REQ-028 Read: rx 52 C3 00 00 13 with bus_rdata=0x12345678 on bus_ready -> bus_addr=0xC3000010, bus_wstrb=0 -> tx 12 34 56 78 in order.
REQ-029 Bad command: rx 0x00 -> tx EE, no bus_valid; a following valid read SHALL complete normally.
REQ-030 Timeout: TIMEOUT_CYCLES=4, read with bus_ready held 0 -> bus_valid high exactly 4 cycles, then 0 -> tx EE.
REQ-031 Backpressure: tx_ack delayed 10 cycles per byte on a read -> tx_data stable while tx_syn=1, 4 bytes sent, no loss; rx bytes sent during BUS stay unacknowledged.
REQ-032 Reset during WDATA after 2 data bytes -> all outputs 0 next cycle; a fresh write then completes with tx A5.

Source files
------------

// File: rtl/host_bus_pkg.sv
// Shared codes and state encodings for the host byte-stream to word-bus bridge.
// Firmware-side tests include the same command and response values.
package host_bus_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'hA5;
   localparam logic [7:0] RSP_ERR   = 8'hEE;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_WDATA = 3'd2;
   localparam logic [2:0] ST_BUS   = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      ADDR  = ST_ADDR,
      WDATA = ST_WDATA,
      BUS   = ST_BUS,
      RESP  = ST_RESP,
      ERR   = ST_ERR
   } state_e;

   // Byte idx of a word, MSB first (idx 0 -> bits 31:24).
   function automatic logic [7:0] rd_byte(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    return word[31:24];
         2'd1:    return word[23:16];
         2'd2:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/bus_timeout.sv
// Counts cycles spent waiting on the bus; flags the last allowed cycle.
module bus_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n || !en_i) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 16'd1;
   end

   // Asserted in the Nth waiting cycle so the request is held exactly N cycles.
   assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/host_bus_master.sv
// Host byte-stream command decoder driving a single-word valid/ready bus.
// state | meaning
// IDLE  | wait for command byte ('W' write, 'R' read)
// ADDR  | collect 4 address bytes, MSB first
// WDATA | collect 4 write-data bytes, MSB first
// BUS   | bus_valid held until bus_ready or timeout
// RESP  | send A5 (write) or 4 read-data bytes
// ERR   | send EE
module host_bus_master
   import host_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_syn,
   input  logic [7:0]  rx_data,
   output logic        rx_ack,
   output logic        tx_syn,
   output logic [7:0]  tx_data,
   input  logic        tx_ack,
   output logic        bus_valid,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   state_e      state_q;
   logic [2:0]  byte_cnt_q;
   logic        is_write_q;
   logic        rx_ack_q;
   logic        tx_syn_q;
   logic [7:0]  tx_data_q;
   logic        bus_valid_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q;
   logic        rx_take;
   logic        tmo_expired;

   assign rx_take = rx_syn && rx_ack_q;

   bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (state_q == BUS),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         is_write_q  <= 1'b0;
         rx_ack_q    <= 1'b0;
         tx_syn_q    <= 1'b0;
         tx_data_q   <= '0;
         bus_valid_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
      end else begin
         rx_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               rx_ack_q <= rx_syn && !rx_ack_q;
               if (rx_take) begin
                  byte_cnt_q <= '0;
                  if (rx_data == CMD_WRITE) begin
                     is_write_q <= 1'b1;
                     state_q    <= ADDR;
                  end else if (rx_data == CMD_READ) begin
                     is_write_q <= 1'b0;
                     state_q    <= ADDR;
                  end else begin
                     state_q    <= ERR;
                  end
               end
            end
            ADDR: begin
               rx_ack_q <= rx_syn && !rx_ack_q;
               if (rx_take) begin
                  // Word address: the low two bits of the last byte are dropped.
                  addr_q <= (byte_cnt_q == 3'd3) ? {addr_q[23:0], rx_data[7:2], 2'b00}
                                                 : {addr_q[23:0], rx_data};
                  if (byte_cnt_q == 3'd3) begin
                     byte_cnt_q <= '0;
                     if (is_write_q) begin
                        state_q <= WDATA;
                     end else begin
                        state_q     <= BUS;
                        bus_valid_q <= 1'b1;
                        wstrb_q     <= 4'h0;
                     end
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 3'd1;
                  end
               end
            end
            WDATA: begin
               rx_ack_q <= rx_syn && !rx_ack_q;
               if (rx_take) begin
                  wdata_q <= {wdata_q[23:0], rx_data};
                  if (byte_cnt_q == 3'd3) begin
                     byte_cnt_q  <= '0;
                     state_q     <= BUS;
                     bus_valid_q <= 1'b1;
                     wstrb_q     <= 4'hf;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 3'd1;
                  end
               end
            end
            BUS: begin
               // A ready arriving in the final allowed cycle still completes.
               if (bus_ready) begin
                  bus_valid_q <= 1'b0;
                  byte_cnt_q  <= '0;
                  state_q     <= RESP;
                  if (!is_write_q) rdata_q <= bus_rdata;
               end else if (tmo_expired) begin
                  bus_valid_q <= 1'b0;
                  state_q     <= ERR;
               end
            end
            RESP: begin
               if (tx_syn_q) begin
                  if (tx_ack) begin
                     tx_syn_q <= 1'b0;
                     if (is_write_q || byte_cnt_q == 3'd3) begin
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                     end else begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                     end
                  end
               end else begin
                  tx_syn_q  <= 1'b1;
                  tx_data_q <= is_write_q ? RSP_OK : rd_byte(rdata_q, byte_cnt_q[1:0]);
               end
            end
            ERR: begin
               if (tx_syn_q) begin
                  if (tx_ack) begin
                     tx_syn_q <= 1'b0;
                     state_q  <= IDLE;
                  end
               end else begin
                  tx_syn_q  <= 1'b1;
                  tx_data_q <= RSP_ERR;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_ack    = rx_ack_q;
   assign tx_syn    = tx_syn_q;
   assign tx_data   = tx_data_q;
   assign bus_valid = bus_valid_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_host_bus_master.sv
// Directed bench: table of write/read transactions plus timeout, bad-command and reset sequences.
module tb_host_bus_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_syn = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ack;
   logic        tx_syn;
   logic [7:0]  tx_data;
   logic        tx_ack = 1'b0;
   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = 32'hBAD0BAD0;

   int checks = 0;
   int errors = 0;
   logic watch_rx = 1'b0, ack_seen = 1'b0;
   logic watch_bus = 1'b0, valid_seen = 1'b0;

   host_bus_master #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_syn(rx_syn), .rx_data(rx_data), .rx_ack(rx_ack),
      .tx_syn(tx_syn), .tx_data(tx_data), .tx_ack(tx_ack),
      .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (watch_rx && rx_ack) ack_seen = 1'b1;
      if (watch_bus && bus_valid) valid_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr_in;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdy_dly;
      int          ack_dly;
      logic        hold_rx;
      logic [31:0] exp_addr;
      logic [3:0]  exp_wstrb;
      int          exp_n;
      logic [31:0] exp_tx;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_syn  = 1'b1;
      rx_data = b;
      while (rx_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rx_ack seen", {31'b0, rx_ack}, 32'd1);
      @(negedge clk);
      rx_syn = 1'b0;
      chk("rx_ack one-cycle pulse", {31'b0, rx_ack}, 32'd0);
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic with_data);
      send_byte(cmd);
      for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8]);
      if (with_data)
         for (int i = 0; i < 4; i++) send_byte(wdata[31-8*i -: 8]);
   endtask

   task automatic recv_bytes(input int n, input logic [31:0] word, input int ack_dly);
      int w;
      int unstable = 0;
      logic [31:0] sh;
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) rx_syn = 1'b0;
         w = 0;
         while (tx_syn !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
         end
         chk("tx_syn presented", {31'b0, tx_syn}, 32'd1);
         sh = word >> (8 * (n - 1 - i));
         chk("tx_data byte", {24'b0, tx_data}, {24'b0, sh[7:0]});
         repeat (ack_dly) begin
            @(negedge clk);
            if (tx_syn !== 1'b1 || tx_data !== sh[7:0]) unstable++;
         end
         tx_ack = 1'b1;
         @(negedge clk);
         tx_ack = 1'b0;
         chk("tx_syn drop after ack", {31'b0, tx_syn}, 32'd0);
      end
      chk("tx held stable under backpressure", unstable, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int bad = 0;
      int extra = 0;
      send_cmd(v.cmd, v.addr_in, v.wdata, v.exp_wstrb == 4'hf);
      if (v.hold_rx) begin
         rx_syn   = 1'b1;
         rx_data  = 8'h57;
         ack_seen = 1'b0;
         watch_rx = 1'b1;
      end
      chk("bus_valid on BUS entry", {31'b0, bus_valid}, 32'd1);
      chk("bus_addr", bus_addr, v.exp_addr);
      chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, v.exp_wstrb});
      if (v.exp_wstrb == 4'hf) chk("bus_wdata", bus_wdata, v.wdata);
      repeat (v.rdy_dly) begin
         @(negedge clk);
         if (bus_valid !== 1'b1 || bus_addr !== v.exp_addr || bus_wstrb !== v.exp_wstrb) bad++;
      end
      chk("bus request held until ready", bad, 0);
      bus_ready = 1'b1;
      bus_rdata = v.rdata;
      @(negedge clk);
      bus_ready = 1'b0;
      bus_rdata = 32'hBAD0BAD0;
      chk("bus_valid drop after ready", {31'b0, bus_valid}, 32'd0);
      recv_bytes(v.exp_n, v.exp_tx, v.ack_dly);
      repeat (3) begin
         @(negedge clk);
         if (tx_syn !== 1'b0) extra++;
      end
      chk("no extra tx byte", extra, 0);
      if (v.hold_rx) begin
         watch_rx = 1'b0;
         chk("rx unacked in BUS/RESP", {31'b0, ack_seen}, 32'd0);
      end
   endtask

   initial begin
      int hi;
      int extra;
      vecs[0] = '{8'h57, 32'h40000008, 32'hDEADBEEF, 32'h0, 3, 0, 1'b0, 32'h40000008, 4'hf, 1, 32'h000000A5};
      vecs[1] = '{8'h52, 32'hC3000013, 32'h0, 32'h12345678, 1, 0, 1'b0, 32'hC3000010, 4'h0, 4, 32'h12345678};
      vecs[2] = '{8'h57, 32'h000000FF, 32'h01020304, 32'h0, 0, 2, 1'b0, 32'h000000FC, 4'hf, 1, 32'h000000A5};
      vecs[3] = '{8'h52, 32'hFFFFFFFE, 32'h0, 32'hA5EE0080, 2, 1, 1'b0, 32'hFFFFFFFC, 4'h0, 4, 32'hA5EE0080};
      vecs[4] = '{8'h52, 32'h00001234, 32'h0, 32'h89ABCDEF, 3, 10, 1'b1, 32'h00001234, 4'h0, 4, 32'h89ABCDEF};

      repeat (3) @(negedge clk);
      chk("reset rx_ack", {31'b0, rx_ack}, 32'd0);
      chk("reset tx_syn", {31'b0, tx_syn}, 32'd0);
      chk("reset bus_valid", {31'b0, bus_valid}, 32'd0);
      chk("reset tx_data", {24'b0, tx_data}, 32'd0);
      chk("reset bus_addr", bus_addr, 32'd0);
      chk("reset bus_wdata", bus_wdata, 32'd0);
      chk("reset bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Unknown command byte: error response, no bus activity, then a normal read.
      valid_seen = 1'b0;
      watch_bus  = 1'b1;
      send_byte(8'h00);
      recv_bytes(1, 32'h000000EE, 0);
      watch_bus = 1'b0;
      chk("no bus request on bad command", {31'b0, valid_seen}, 32'd0);
      run_vec(vecs[1]);

      // Timeout with TIMEOUT_CYCLES=4.
      send_cmd(8'h52, 32'h00000020, 32'h0, 1'b0);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_valid === 1'b1) hi++;
         @(negedge clk);
      end
      chk("timeout bus_valid cycles", hi, 4);
      chk("bus_valid low after timeout", {31'b0, bus_valid}, 32'd0);
      recv_bytes(1, 32'h000000EE, 0);
      run_vec(vecs[0]);

      // Reset during WDATA after two data bytes.
      send_byte(8'h57);
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
      send_byte(8'hCA);
      send_byte(8'hFE);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid reset rx_ack", {31'b0, rx_ack}, 32'd0);
      chk("mid reset tx_syn", {31'b0, tx_syn}, 32'd0);
      chk("mid reset bus_valid", {31'b0, bus_valid}, 32'd0);
      chk("mid reset tx_data", {24'b0, tx_data}, 32'd0);
      chk("mid reset bus_addr", bus_addr, 32'd0);
      chk("mid reset bus_wdata", bus_wdata, 32'd0);
      chk("mid reset bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
      reset_n = 1'b1;
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (tx_syn !== 1'b0 || bus_valid !== 1'b0) extra++;
      end
      chk("no response after reset", extra, 0);
      run_vec(vecs[2]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
